// File: rtl/uart_word_tx_pkg.sv
// Shared encodings and constants for the uart_word_tx slice.
// UART_WORD_TX_HEX_EN selects ASCII-hex framing (10 characters per word) instead of 4 raw bytes.
package uart_word_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  localparam int DEF_BIT_CYCLES = 50;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;

`ifdef UART_WORD_TX_HEX_EN
  localparam int BYTES_PER_WORD = 10;
`else
  localparam int BYTES_PER_WORD = 4;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'd0, nib};
    end else begin
      return ASCII_A + {4'd0, nib} - 8'd10;
    end
  endfunction

  // Index 0 is the most significant nibble.
  function automatic logic [3:0] hex_nibble(input logic [31:0] w, input logic [2:0] idx);
    return w[{3'd7 - idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with registered full/empty flags; the caller qualifies push and pop.
module uart_word_fifo #(
  parameter int AW = 3,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (i_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == {(AW+1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;

endmodule

// File: rtl/uart_word_tx.sv
// Buffered 32-bit word UART transmitter, 8N1, LSB byte and LSB bit first.
// Define UART_WORD_TX_HEX_EN to send each word as 8 hex digits followed by CR LF.
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int FIFO_AW    = 3
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        i_we,
  input  logic [31:0] i_data,
  output logic        o_full,
  output logic        o_ovf,
  output logic        o_busy,
  output logic        o_txd
);

  localparam int            CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(BYTES_PER_WORD - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_q, word_d;
  logic          txd_q, txd_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [31:0]   fifo_rdata;
  logic          wrap;
  logic [7:0]    nxt_byte;

  uart_word_fifo #(
    .AW (FIFO_AW),
    .DW (32)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_X),
    .i_push  (fifo_push),
    .i_wdata (i_data),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    fifo_pop   = 1'b0;
    wrap       = (cnt_q == CNT_MAX);
    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        fifo_pop   = 1'b1;
        word_d     = fifo_rdata;
        byte_idx_d = 4'd0;
        bit_idx_d  = 3'd0;
        cnt_d      = {CW{1'b0}};
        state_d    = ST_START;
      end
      ST_START: begin
        if (wrap) begin
          cnt_d     = {CW{1'b0}};
          bit_idx_d = 3'd0;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (wrap) begin
          cnt_d = {CW{1'b0}};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (wrap) begin
          cnt_d = {CW{1'b0}};
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 4'd1;
`ifndef UART_WORD_TX_HEX_EN
            word_d     = {8'd0, word_q[31:8]};
`endif
            state_d    = ST_START;
          end else if (!fifo_empty) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken then.
  always_comb begin
    fifo_push = i_we & (~fifo_full | fifo_pop);
    ovf_d     = ovf_q | (i_we & ~fifo_push);
    busy_d    = (state_d != ST_IDLE) | fifo_push | ~fifo_empty;
`ifdef UART_WORD_TX_HEX_EN
    if (byte_idx_d == 4'd8) begin
      nxt_byte = ASCII_CR;
    end else if (byte_idx_d == 4'd9) begin
      nxt_byte = ASCII_LF;
    end else begin
      nxt_byte = hex_char(hex_nibble(word_d, byte_idx_d[2:0]));
    end
`else
    nxt_byte = word_d[7:0];
`endif
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = nxt_byte[bit_idx_d];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      word_q     <= 32'd0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign o_full = fifo_full;
  assign o_ovf  = ovf_q;
  assign o_busy = busy_q;
  assign o_txd  = txd_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Randomised scoreboard bench for uart_word_tx: transaction-level model plus a UART receiver monitor.
module tb_uart_word_tx;

`ifdef UART_WORD_TX_HEX_EN
  localparam int BPW = 10;
`else
  localparam int BPW = 4;
`endif
  localparam int BC       = 50;
  localparam int DEPTH    = 8;
  localparam int WORD_CYC = BPW * 10 * BC;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic        o_full, o_ovf, o_busy, o_txd;

  int errors = 0;
  int checks = 0;

  // Transaction-level model state.
  logic [31:0] mq[$];
  logic [7:0]  exp_q[$];
  int          tleft = 0;
  bit          load_pending = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_rst = 1'b1;
  bit          chk_en = 1'b0;

  // Receiver state.
  bit          rx_act = 1'b0;
  int          rx_cnt = 0;
  logic [7:0]  rx_byte = 8'd0;

  always #5 CLK = ~CLK;

  uart_word_tx #(.BIT_CYCLES(BC), .FIFO_AW(3)) dut (
    .CLK    (CLK),
    .RST_X  (RST_X),
    .i_we   (i_we),
    .i_data (i_data),
    .o_full (o_full),
    .o_ovf  (o_ovf),
    .o_busy (o_busy),
    .o_txd  (o_txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word_bytes(input logic [31:0] w);
`ifdef UART_WORD_TX_HEX_EN
    for (int i = 0; i < 8; i++) begin
      logic [3:0] nib;
      nib = w[28 - 4*i +: 4];
      exp_q.push_back((nib < 4'd10) ? (8'h30 + {4'd0, nib}) : (8'h41 + {4'd0, nib} - 8'd10));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
`endif
  endfunction

  function automatic bit m_busy();
    return load_pending || (tleft > 0) || (mq.size() > 0);
  endfunction

  // One clock of the reference: a word occupies the line for WORD_CYC clocks, a pop
  // happens one clock after the serialiser sees a non-empty FIFO while free.
  task automatic model_step();
    bit pop;
    int size_pre;
    if (!RST_X) begin
      mq.delete();
      exp_q.delete();
      tleft = 0;
      load_pending = 1'b0;
      m_ovf = 1'b0;
      m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    pop = 1'b0;
    size_pre = mq.size();
    if (load_pending) begin
      pop = 1'b1;
      load_pending = 1'b0;
      void'(mq.pop_front());
      tleft = WORD_CYC;
    end else if (tleft > 0) begin
      tleft--;
      if (tleft == 0 && size_pre > 0) load_pending = 1'b1;
    end else if (size_pre > 0) begin
      load_pending = 1'b1;
    end
    if (i_we) begin
      if (size_pre < DEPTH || pop) begin
        mq.push_back(i_data);
        push_word_bytes(i_data);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Receiver: samples mid-bit, compares each decoded byte with the scoreboard head.
  task automatic rx_step();
    if (m_rst || !chk_en) begin
      rx_act = 1'b0;
      return;
    end
    if (!rx_act) begin
      if (o_txd === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == BC/2) begin
        check("start_bit", {31'd0, o_txd}, 32'd0);
      end else if (rx_cnt >= BC/2 + BC && rx_cnt <= BC/2 + 8*BC && (rx_cnt - BC/2) % BC == 0) begin
        rx_byte[(rx_cnt - BC/2 - BC) / BC] = o_txd;
      end else if (rx_cnt == BC/2 + 9*BC) begin
        check("stop_bit", {31'd0, o_txd}, 32'd1);
        rx_act = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_byte: got unexpected byte %0h expected none", rx_byte);
        end else begin
          check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  endtask

  initial forever begin
    @(negedge CLK);
    rx_step();
    if (chk_en) begin
      check("o_full", {31'd0, o_full}, {31'd0, mq.size() == DEPTH});
      check("o_ovf",  {31'd0, o_ovf},  {31'd0, m_ovf});
      check("o_busy", {31'd0, o_busy}, {31'd0, m_busy()});
    end
  end

  task automatic drive_cycle(input bit we, input logic [31:0] d);
    @(negedge CLK);
    i_we = we;
    i_data = d;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((m_busy() || rx_act || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (m_busy() || rx_act || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: drain incomplete, %0d bytes outstanding after %0d cycles", name, exp_q.size(), n);
    end
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    int n;
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RST_X = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_txd",  {31'd0, o_txd},  32'd1);
    check("rst_full", {31'd0, o_full}, 32'd0);
    check("rst_ovf",  {31'd0, o_ovf},  32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    chk_en = 1'b1;
    RST_X = 1'b1;

    // Single word and start-bit latency.
    drive_cycle(1'b1, 32'h12345678);
    drive_cycle(1'b0, $urandom);
    @(negedge CLK);
    check("lat_t1", {31'd0, o_txd}, 32'd1);
    @(negedge CLK);
    check("lat_t2", {31'd0, o_txd}, 32'd0);
    wait_idle("single", WORD_CYC + 100);

    // Back-to-back words.
    drive_cycle(1'b1, 32'hDEADBEEF);
    drive_cycle(1'b1, 32'h00000001);
    drive_cycle(1'b0, $urandom);
    wait_idle("b2b", 2*WORD_CYC + 100);

    // Fill, write during the pop cycle, then overflow.
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, i);
    drive_cycle(1'b0, $urandom);
    n = 0;
    while (!load_pending && n < WORD_CYC + 100) begin
      @(negedge CLK);
      n++;
    end
    check("pop_wait", {31'd0, load_pending}, 32'd1);
    i_we = 1'b1;
    i_data = 32'hC0DE0009;
    @(negedge CLK);
    check("simul_full", {31'd0, o_full}, 32'd1);
    check("simul_ovf",  {31'd0, o_ovf},  32'd0);
    for (int i = 0; i < 10; i++) begin
      i_we = 1'b1;
      i_data = 32'hBAD00000 + i;
      @(negedge CLK);
    end
    i_we = 1'b0;
    check("ovf_set",  {31'd0, o_ovf},  32'd1);
    check("ovf_full", {31'd0, o_full}, 32'd1);
    wait_idle("overflow", 10*(WORD_CYC + 1) + 200);

    // Reset in the middle of data bit 3 of the first byte.
    drive_cycle(1'b1, $urandom);
    drive_cycle(1'b0, $urandom);
    n = 0;
    while (tleft != WORD_CYC - (BC + 3*BC + BC/2) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    RST_X = 1'b0;
    @(negedge CLK);
    check("midrst_txd",  {31'd0, o_txd},  32'd1);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    RST_X = 1'b1;
    drive_cycle(1'b1, 32'hA5A5A5A5);
    drive_cycle(1'b0, $urandom);
    wait_idle("after_rst", WORD_CYC + 100);

    // Random words with random spacing, including the hex example word.
    drive_cycle(1'b1, 32'h00C0FFEE);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, $urandom);
      repeat ($urandom_range(0, 1500)) @(negedge CLK);
      drive_cycle(1'b1, $urandom);
    end
    drive_cycle(1'b0, $urandom);
    wait_idle("random", 6*(WORD_CYC + 1) + 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
